vector_operand_sequencer: RTL and testbench

//   Upstream feeder of the vector function unit: accepts one vector instruction (full vs1/vs2 operands, mask, vl, op)
//   and slices it into ceil(vl/LANE_SIZE) beats of LANE_SIZE elements each. Beats go to the lane inputs over a

---
 rtl/vector_operand_sequencer.sv | 125 ++++++++++++
 tb/tb_vector_operand_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_sequencer.sv
// Vector operand sequencer: slices one latched vector instruction into
// LANE_SIZE-element beats over valid/ready, then pulses done.
module vector_operand_sequencer #(
   parameter int LEN              = 32,
   parameter int VECTOR_SIZE      = 8,
   parameter int ENTRY_INDEX_SIZE = 3,
   parameter int LANE_SIZE        = 2,
   parameter int LANE_INDEX_SIZE  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [4:0]                    in_alu_op,
   input  logic [VECTOR_SIZE*LEN-1:0]    in_vs1,
   input  logic [VECTOR_SIZE*LEN-1:0]    in_vs2,
   input  logic [VECTOR_SIZE-1:0]        in_mask,
   input  logic [ENTRY_INDEX_SIZE:0]     in_vl,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [4:0]                    out_alu_op,
   output logic [LANE_SIZE*LEN-1:0]      out_vs1,
   output logic [LANE_SIZE*LEN-1:0]      out_vs2,
   output logic [LANE_SIZE-1:0]          out_mask,
   output logic [ENTRY_INDEX_SIZE-1:0]   out_base_idx,
   output logic                          out_last,
   output logic                          done
);

   localparam int CW = ENTRY_INDEX_SIZE + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t               state, state_next;
   logic [CW-1:0]        k, k_next;
   logic [CW-1:0]        vl_q, beats_q;
   logic [CW-1:0]        vl_eff, beats_in, base;
   logic [LEN-1:0]       vs1_q [VECTOR_SIZE];
   logic [LEN-1:0]       vs2_q [VECTOR_SIZE];
   logic [VECTOR_SIZE-1:0] mask_q;
   logic [4:0]           op_q;
   logic                 done_next;
   logic                 issuing;

   assign vl_eff   = (in_vl > CW'(VECTOR_SIZE)) ? CW'(VECTOR_SIZE) : in_vl;
   assign beats_in = (vl_eff + CW'(LANE_SIZE - 1)) >> LANE_INDEX_SIZE;
   assign issuing  = (state == ISSUE);
   assign base     = k << LANE_INDEX_SIZE;
   assign out_last = issuing && (k == beats_q - CW'(1));

   always_comb begin
      state_next = state;
      k_next     = k;
      done_next  = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               k_next = '0;
               if (vl_eff == '0) done_next = 1'b1;
               else state_next = ISSUE;
            end
         end
         ISSUE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (out_last) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  k_next = k + CW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         k       <= '0;
         done    <= 1'b0;
         vl_q    <= '0;
         beats_q <= '0;
         mask_q  <= '0;
         op_q    <= '0;
         for (int j = 0; j < VECTOR_SIZE; j++) begin
            vs1_q[j] <= '0;
            vs2_q[j] <= '0;
         end
      end else begin
         state <= state_next;
         k     <= k_next;
         done  <= done_next;
         if (state == IDLE && in_valid) begin
            vl_q    <= vl_eff;
            beats_q <= beats_in;
            mask_q  <= in_mask;
            op_q    <= in_alu_op;
            for (int j = 0; j < VECTOR_SIZE; j++) begin
               vs1_q[j] <= in_vs1[j*LEN +: LEN];
               vs2_q[j] <= in_vs2[j*LEN +: LEN];
            end
         end
      end
   end

   assign out_alu_op   = issuing ? op_q : 5'd0;
   assign out_base_idx = issuing ? base[ENTRY_INDEX_SIZE-1:0] : '0;

   // Lanes past vl carry zero data and a cleared enable
   for (genvar g = 0; g < LANE_SIZE; g++) begin : g_lane
      logic [CW-1:0] idx;
      logic          act;
      assign idx = base + CW'(g);
      assign act = issuing && (idx < vl_q);
      assign out_vs1[g*LEN +: LEN] = act ? vs1_q[idx[ENTRY_INDEX_SIZE-1:0]] : '0;
      assign out_vs2[g*LEN +: LEN] = act ? vs2_q[idx[ENTRY_INDEX_SIZE-1:0]] : '0;
      assign out_mask[g] = act & mask_q[idx[ENTRY_INDEX_SIZE-1:0]];
   end

endmodule

// File: tb/tb_vector_operand_sequencer.sv
// Directed bench for vector_operand_sequencer with an expected-beat
// scoreboard queue filled at issue and drained as beats appear.
module tb_vector_operand_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   in_alu_op;
   logic [255:0] in_vs1;
   logic [255:0] in_vs2;
   logic [7:0]   in_mask;
   logic [3:0]   in_vl;
   logic         out_valid;
   logic         out_ready;
   logic [4:0]   out_alu_op;
   logic [63:0]  out_vs1;
   logic [63:0]  out_vs2;
   logic [1:0]   out_mask;
   logic [2:0]   out_base_idx;
   logic         out_last;
   logic         done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]  op;
      logic [63:0] vs1;
      logic [63:0] vs2;
      logic [1:0]  mask;
      logic [2:0]  base;
      logic        last;
   } beat_t;

   beat_t q[$];

   vector_operand_sequencer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_vs1(in_vs1), .in_vs2(in_vs2),
      .in_mask(in_mask), .in_vl(in_vl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_op(out_alu_op), .out_vs1(out_vs1), .out_vs2(out_vs2),
      .out_mask(out_mask), .out_base_idx(out_base_idx),
      .out_last(out_last), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_beats(input logic [4:0] op, input logic [255:0] v1,
                             input logic [255:0] v2, input logic [7:0] m,
                             input int vl);
      int ve;
      int nb;
      ve = (vl > 8) ? 8 : vl;
      nb = (ve + 1) / 2;
      for (int kk = 0; kk < nb; kk++) begin
         beat_t b;
         logic [63:0] a1;
         logic [63:0] a2;
         logic [1:0]  am;
         a1 = '0; a2 = '0; am = '0;
         for (int i = 0; i < 2; i++) begin
            int idx;
            idx = kk * 2 + i;
            if (idx < ve) begin
               a1[i*32 +: 32] = v1[idx*32 +: 32];
               a2[i*32 +: 32] = v2[idx*32 +: 32];
               am[i] = m[idx];
            end
         end
         b.op = op; b.vs1 = a1; b.vs2 = a2; b.mask = am;
         b.base = 3'(kk * 2);
         b.last = (kk == nb - 1);
         q.push_back(b);
      end
   endtask

   // Called at a negedge; drives the offer and returns one negedge later
   task automatic issue(input logic [4:0] op, input logic [255:0] v1,
                        input logic [255:0] v2, input logic [7:0] m,
                        input int vl, input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_alu_op = op; in_vs1 = v1; in_vs2 = v2;
      in_mask = m; in_vl = 4'(vl);
      push_beats(op, v1, v2, m, vl);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int stall_beat, input int stall_n,
                        input int exp_done, input string tag);
      int c;
      int popped;
      int stalled;
      int done_c;
      beat_t b;
      c = 1; popped = 0; stalled = 0; done_c = -1;
      while (c <= 60) begin
         if (done) begin
            done_c = c;
            break;
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk({tag, "_extra_beat"}, 64'd1, 64'd0);
            end else begin
               b = q[0];
               chk({tag, "_op"}, 64'(out_alu_op), 64'(b.op));
               chk({tag, "_vs1"}, out_vs1, b.vs1);
               chk({tag, "_vs2"}, out_vs2, b.vs2);
               chk({tag, "_mask"}, 64'(out_mask), 64'(b.mask));
               chk({tag, "_base"}, 64'(out_base_idx), 64'(b.base));
               chk({tag, "_last"}, 64'(out_last), 64'(b.last));
               chk({tag, "_busy"}, 64'(in_ready), 64'd0);
            end
         end
         if (out_valid && popped == stall_beat && stalled < stall_n) begin
            out_ready = 1'b0;
            stalled++;
            in_valid = 1'b1; in_alu_op = 5'h1f; in_vl = 4'd8;
            in_vs1 = '1; in_vs2 = '1; in_mask = '1;
         end else begin
            out_ready = 1'b1;
            in_valid = 1'b0;
            if (out_valid && q.size() > 0) begin
               void'(q.pop_front());
               popped++;
            end
         end
         @(negedge clk);
         c++;
      end
      chk({tag, "_done_cycle"}, 64'(done_c), 64'(exp_done));
      chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
      out_ready = 1'b1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [255:0] va;
      logic [255:0] vb;
      rst = 1'b1; in_valid = 1'b0; in_alu_op = '0; in_vs1 = '0;
      in_vs2 = '0; in_mask = '0; in_vl = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out_vs1", out_vs1, 64'd0);
      chk("rst_out_mask", 64'(out_mask), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_base", 64'(out_base_idx), 64'd0);
      chk("rst_out_op", 64'(out_alu_op), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int j = 0; j < 8; j++) begin
         va[j*32 +: 32] = 32'(j + 1);
         vb[j*32 +: 32] = $urandom;
      end

      // 1: full vector
      issue(5'h03, va, vb, 8'hFF, 8, "full");
      drain(-1, 0, 5, "full");
      @(negedge clk);
      chk("full_done_pulse", 64'(done), 64'd0);

      // 2: partial vector
      issue(5'h07, va, vb, 8'hFF, 5, "partial");
      drain(-1, 0, 4, "partial");
      @(negedge clk);

      // 3: mask pattern
      issue(5'h0a, vb, va, 8'b1010_0101, 8, "maskpat");
      drain(-1, 0, 5, "maskpat");
      @(negedge clk);

      // 4: backpressure on beat 1, ignored offers meanwhile
      issue(5'h11, va, vb, 8'h5A, 8, "stall");
      drain(1, 3, 8, "stall");
      @(negedge clk);

      // 5: vl = 0, clamped vl, back-to-back in done cycle
      issue(5'h02, va, vb, 8'hFF, 0, "vl0");
      drain(-1, 0, 1, "vl0");
      @(negedge clk);
      issue(5'h04, vb, va, 8'hC3, 12, "vl12");
      drain(-1, 0, 5, "vl12");
      issue(5'h05, va, va, 8'h3C, 3, "b2b");
      drain(-1, 0, 3, "b2b");
      @(negedge clk);

      // 6: reset during beat 2
      issue(5'h09, va, vb, 8'hFF, 8, "rstmid");
      @(negedge clk);
      chk("rstmid_beat2_base", 64'(out_base_idx), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_out_valid", 64'(out_valid), 64'd0);
      chk("rstmid_in_ready", 64'(in_ready), 64'd1);
      chk("rstmid_done", 64'(done), 64'd0);
      chk("rstmid_out_vs1", out_vs1, 64'd0);
      @(negedge clk);
      chk("rstmid_no_done", 64'(done), 64'd0);
      chk("rstmid_idle", 64'(out_valid), 64'd0);
      q.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
